// File: rtl/corretor_hamming_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : corretor_hamming_if
// Brief    : Codeword input stream and corrected-word output stream for
//            the Hamming(15,11) corrector.
// Revision : 1.0
// ============================================================================
interface corretor_hamming_if;
    logic [14:0] entrada;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] saida;
    logic [10:0] dados;
    logic [3:0]  sindrome;
    logic        corrigido;
    logic        out_valid;
    logic        out_ready;

    modport slave (
        input  entrada, in_valid, out_ready,
        output in_ready, saida, dados, sindrome, corrigido, out_valid
    );

    modport master (
        output entrada, in_valid, out_ready,
        input  in_ready, saida, dados, sindrome, corrigido, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/corretor_hamming.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : corretor_hamming
// Brief    : Two-stage Hamming(15,11) single-error corrector with valid/ready
//            handshake and a saturating count of corrected words.
// Revision : 1.0
// ============================================================================
module corretor_hamming #(
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    corretor_hamming_if.slave     bus,
    input  wire logic             limpar_cnt,
    output logic [CNT_W-1:0]      cnt_corrigidos
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              s1_valid_q, s1_valid_d;
    logic [14:0]       s1_word_q,  s1_word_d;
    logic [3:0]        s1_sind_q,  s1_sind_d;
    logic              out_valid_q, out_valid_d;
    logic [14:0]       saida_q,    saida_d;
    logic [10:0]       dados_q,    dados_d;
    logic [3:0]        sind_q,     sind_d;
    logic              corr_q,     corr_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;

    logic              adv1;
    logic              adv2;
    logic [3:0]        sind_in;
    logic [14:0]       flip_mask;
    logic [14:0]       s1_fixed;

    // Syndrome bit k is the parity of every position whose index has bit k set.
    always_comb begin
        logic [3:0] pos;
        sind_in = '0;
        for (int p = 1; p <= 15; p++) begin
            pos = 4'(p);
            for (int k = 0; k < 4; k++) begin
                if (pos[k]) begin
                    sind_in[k] = sind_in[k] ^ bus.entrada[p-1];
                end
            end
        end
    end

    // One-hot flip of the position named by the syndrome; zero syndrome flips nothing.
    always_comb begin
        for (int p = 1; p <= 15; p++) begin
            flip_mask[p-1] = (s1_sind_q == 4'(p));
        end
        s1_fixed = s1_word_q ^ flip_mask;
    end

    always_comb begin
        adv2        = !out_valid_q || bus.out_ready;
        adv1        = !s1_valid_q || adv2;

        s1_valid_d  = s1_valid_q;
        s1_word_d   = s1_word_q;
        s1_sind_d   = s1_sind_q;
        out_valid_d = out_valid_q;
        saida_d     = saida_q;
        dados_d     = dados_q;
        sind_d      = sind_q;
        corr_d      = corr_q;
        cnt_d       = cnt_q;

        if (adv1) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_word_d = bus.entrada;
                s1_sind_d = sind_in;
            end
        end

        if (adv2) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                saida_d = s1_fixed;
                dados_d = {s1_fixed[14:8], s1_fixed[6:4], s1_fixed[2]};
                sind_d  = s1_sind_q;
                corr_d  = |s1_sind_q;
            end
        end

        // Clear takes priority over a simultaneous increment.
        if (limpar_cnt) begin
            cnt_d = '0;
        end else if (out_valid_q && bus.out_ready && corr_q && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_word_q   <= '0;
            s1_sind_q   <= '0;
            out_valid_q <= 1'b0;
            saida_q     <= '0;
            dados_q     <= '0;
            sind_q      <= '0;
            corr_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_word_q   <= s1_word_d;
            s1_sind_q   <= s1_sind_d;
            out_valid_q <= out_valid_d;
            saida_q     <= saida_d;
            dados_q     <= dados_d;
            sind_q      <= sind_d;
            corr_q      <= corr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.in_ready   = adv1;
    assign bus.out_valid  = out_valid_q;
    assign bus.saida      = saida_q;
    assign bus.dados      = dados_q;
    assign bus.sindrome   = sind_q;
    assign bus.corrigido  = corr_q;
    assign cnt_corrigidos = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_corretor_hamming.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_corretor_hamming
// Brief    : Directed bench for corretor_hamming with a positional Hamming model.
// Revision : 1.0
// ============================================================================
module tb_corretor_hamming;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [14:0] saida;
        logic [10:0] dados;
        logic [3:0]  sind;
        logic        corr;
    } exp_t;

    logic             clk        = 1'b0;
    logic             rst_n      = 1'b1;
    logic             limpar_cnt = 1'b0;
    logic [CNT_W-1:0] cnt_corrigidos;

    corretor_hamming_if bus();

    corretor_hamming #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .limpar_cnt     (limpar_cnt),
        .cnt_corrigidos (cnt_corrigidos)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];
    int   mcnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic bit is_parity_pos(input int p);
        return (p & (p - 1)) == 0;
    endfunction

    function automatic int syndrome_of(input logic [14:0] w);
        int s = 0;
        for (int p = 1; p <= 15; p++) if (w[p-1]) s = s ^ p;
        return s;
    endfunction

    function automatic logic [14:0] encode(input logic [10:0] d);
        logic [14:0] w = '0;
        int k = 0;
        int s;
        for (int p = 1; p <= 15; p++) begin
            if (!is_parity_pos(p)) begin
                w[p-1] = d[k];
                k++;
            end
        end
        s = syndrome_of(w);
        for (int j = 0; j < 4; j++) if (s[j]) w[(1 << j) - 1] = 1'b1;
        return w;
    endfunction

    function automatic exp_t model(input logic [14:0] r);
        exp_t e;
        int s = syndrome_of(r);
        int k = 0;
        e.saida = r;
        if (s != 0) e.saida[s-1] = ~e.saida[s-1];
        e.dados = '0;
        for (int p = 1; p <= 15; p++) begin
            if (!is_parity_pos(p)) begin
                e.dados[k] = e.saida[p-1];
                k++;
            end
        end
        e.sind = 4'(s);
        e.corr = (s != 0);
        return e;
    endfunction

    // Scoreboard: accepted words are modelled, outputs compared in order, count tracked.
    always @(negedge clk) begin : monitor
        exp_t cur;
        exp_t prev;
        logic held;
        logic fire_corr;
        if (!rst_n) begin
            q.delete();
            mcnt = 0;
            held = 1'b0;
            chk("rst_out_valid", 32'(bus.out_valid), 0);
            chk("rst_cnt", 32'(cnt_corrigidos), 0);
            chk("rst_in_ready", 32'(bus.in_ready), 1);
        end else begin
            cur = '{bus.saida, bus.dados, bus.sindrome, bus.corrigido};
            chk("cnt", 32'(cnt_corrigidos), 32'(mcnt));
            if (held) chk("hold_stable", 32'(cur), 32'(prev));
            fire_corr = 1'b0;
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    chk("out_word", 32'(cur), 32'(q[0]));
                    fire_corr = bus.out_ready && q[0].corr;
                    if (bus.out_ready) void'(q.pop_front());
                end
            end
            if (limpar_cnt) mcnt = 0;
            else if (fire_corr && mcnt < CNT_MAX) mcnt++;
            held = bus.out_valid && !bus.out_ready;
            prev = cur;
            if (bus.in_valid && bus.in_ready) q.push_back(model(bus.entrada));
        end
    end

    task automatic send(input logic [14:0] w);
        int t = 0;
        bus.entrada  = w;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && t < 50) begin
            t++;
            @(negedge clk);
        end
        if (t >= 50) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.entrada  = 15'($urandom);
    endtask

    // Requires an empty pipeline and out_ready=1; also pins the two-cycle latency.
    task automatic send_and_expect(input string name, input logic [14:0] w,
                                   input logic [14:0] es, input logic [10:0] ed,
                                   input logic [3:0] esd, input logic ec);
        send(w);
        @(negedge clk);
        chk({name, "_lat1_valid"}, 32'(bus.out_valid), 0);
        @(negedge clk);
        chk({name, "_valid"}, 32'(bus.out_valid), 1);
        chk({name, "_saida"}, 32'(bus.saida), 32'(es));
        chk({name, "_dados"}, 32'(bus.dados), 32'(ed));
        chk({name, "_sind"},  32'(bus.sindrome), 32'(esd));
        chk({name, "_corr"},  32'(bus.corrigido), 32'(ec));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic [10:0] d;
        logic [14:0] c;
        bus.entrada   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_out_valid", 32'(bus.out_valid), 0);
        chk("reset_saida",     32'(bus.saida), 0);
        chk("reset_dados",     32'(bus.dados), 0);
        chk("reset_sind",      32'(bus.sindrome), 0);
        chk("reset_corr",      32'(bus.corrigido), 0);
        chk("reset_cnt",       32'(cnt_corrigidos), 0);
        chk("reset_in_ready",  32'(bus.in_ready), 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        send_and_expect("t1_zero", 15'h0000, 15'h0000, 11'h000, 4'd0, 1'b0);
        send_and_expect("t2_pos5", 15'h0010, 15'h0000, 11'h000, 4'd5, 1'b1);
        chk("t2_cnt", 32'(cnt_corrigidos), 1);
        send_and_expect("t3_pos1", 15'h7FFE, 15'h7FFF, 11'h7FF, 4'd1, 1'b1);

        for (int n = 1; n <= 15; n++) begin
            d = 11'($urandom);
            c = encode(d);
            send_and_expect("sweep", c ^ (15'd1 << (n - 1)), c, d, 4'(n), 1'b1);
        end

        for (int i = 0; i < 10; i++) begin
            c = encode(11'($urandom));
            send((i % 3 == 0) ? c : (c ^ (15'd1 << (i % 15))));
        end
        idle(4);

        // Backpressure: two words fill the pipe, the third must wait.
        bus.out_ready = 1'b0;
        send(encode(11'h155) ^ 15'h0100);
        send(encode(11'h2AA));
        bus.entrada  = encode(11'h0F0) ^ 15'h4000;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_in_ready_low", 32'(bus.in_ready), 0);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(negedge clk);
        chk("t4_in_ready_back", 32'(bus.in_ready), 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        idle(5);
        chk("t4_all_drained", 32'(q.size()), 0);

        // Saturation with a 4-bit counter.
        limpar_cnt = 1'b1;
        idle(1);
        limpar_cnt = 1'b0;
        chk("t5_cleared", 32'(cnt_corrigidos), 0);
        for (int i = 0; i < 20; i++) begin
            c = encode(11'($urandom));
            send(c ^ (15'd1 << (i % 15)));
        end
        idle(5);
        chk("t5_saturated", 32'(cnt_corrigidos), 15);
        limpar_cnt = 1'b1;
        idle(1);
        limpar_cnt = 1'b0;
        chk("t5_clear_again", 32'(cnt_corrigidos), 0);
        send(15'h0400);
        idle(1);
        limpar_cnt = 1'b1;
        idle(1);
        limpar_cnt = 1'b0;
        chk("t5_clear_wins", 32'(cnt_corrigidos), 0);
        send_and_expect("t5_after", 15'h0002, 15'h0000, 11'h000, 4'd2, 1'b1);
        chk("t5_inc_after_clear", 32'(cnt_corrigidos), 1);

        // Reset with two words in flight.
        bus.out_ready = 1'b0;
        send(15'h0010);
        send(15'h7FFE);
        rst_n = 1'b0;
        #1;
        chk("t6_out_valid", 32'(bus.out_valid), 0);
        chk("t6_cnt", 32'(cnt_corrigidos), 0);
        chk("t6_in_ready", 32'(bus.in_ready), 1);
        chk("t6_saida", 32'(bus.saida), 0);
        idle(1);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        idle(1);
        send_and_expect("t6_first", 15'h0001, 15'h0000, 11'h000, 4'd1, 1'b1);
        idle(3);
        chk("final_queue_empty", 32'(q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        n_bad++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
